sdac_ctrl: RTL

Sequencer for the 12-bit serial DAC path of the sine-wave generator. It accepts parallel samples from the waveform source through a valid/ready handshake and holds them in a one-deep buffer. At a fixed sample period it serializes each sample MSB-first onto `SI` with `en_SI` asserted, then pulses `soc` for one clock to trigger the DAC conversion. It sits between the sample generator and the serial-in DAC; if the source misses a period, it repeats the previous sample and counts an underrun.

---
 rtl/sdac_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/sdac_ctrl.sv
// Serial DAC sequencer: buffers one parallel sample and emits one frame every PERIOD clocks.
// Each frame shifts the word out MSB-first on SI, pulses soc, and repeats the previous word on underrun.
module sdac_ctrl #(
   parameter int unsigned N      = 12,
   parameter int unsigned PERIOD = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         run,
   input  logic [N-1:0] sample_data,
   input  logic         sample_valid,
   output logic         sample_ready,
   output logic         SI,
   output logic         en_SI,
   output logic         soc,
   output logic         busy,
   output logic [7:0]   underrun_cnt
);

   localparam int unsigned CW = 16;
   localparam int unsigned UW = 8;

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CONV, WAIT} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    buf_q, buf_d;
   logic [N-1:0]    last_q, last_d;
   logic [N-1:0]    shreg_q, shreg_d;
   logic            buf_full_q, buf_full_d;
   logic [UW-1:0]   underrun_q, underrun_d;
   logic            busy_q, en_si_q, soc_q, ready_q;
   logic            accept;

   // State, datapath and output registers; outputs are decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         buf_q      <= '0;
         last_q     <= {1'b1, {(N-1){1'b0}}};
         shreg_q    <= '0;
         buf_full_q <= 1'b0;
         underrun_q <= '0;
         busy_q     <= 1'b0;
         en_si_q    <= 1'b0;
         soc_q      <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         buf_q      <= buf_d;
         last_q     <= last_d;
         shreg_q    <= shreg_d;
         buf_full_q <= buf_full_d;
         underrun_q <= underrun_d;
         busy_q     <= (state_d != IDLE);
         en_si_q    <= (state_d == SHIFT);
         soc_q      <= (state_d == CONV);
         ready_q    <= !buf_full_d;
      end
   end

   assign accept = sample_valid && ready_q;

   // Next-state, buffer and frame sequencing
   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      last_d     = last_q;
      shreg_d    = shreg_q;
      underrun_d = underrun_q;

      if (accept) begin
         buf_d      = sample_data;
         buf_full_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (run) state_d = LOAD;
         end
         LOAD: begin
            if (buf_full_q) begin
               shreg_d    = buf_q;
               last_d     = buf_q;
               buf_full_d = 1'b0;
            end else begin
               shreg_d = last_q;
               if (underrun_q != {UW{1'b1}}) underrun_d = underrun_q + UW'(1);
            end
            state_d = SHIFT;
         end
         SHIFT: begin
            // Shreg drains to zero, so SI idles low between frames
            shreg_d = {shreg_q[N-2:0], 1'b0};
            if (cnt_q == CW'(N)) state_d = CONV;
         end
         CONV: begin
            if (PERIOD == N + 2) state_d = run ? LOAD : IDLE;
            else                 state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == CW'(PERIOD - 1)) state_d = run ? LOAD : IDLE;
         end
         default: state_d = IDLE;
      endcase

      cnt_d = ((state_d == LOAD) || (state_d == IDLE)) ? '0 : cnt_q + CW'(1);
   end

   assign sample_ready = ready_q;
   assign SI           = shreg_q[N-1];
   assign en_SI        = en_si_q;
   assign soc          = soc_q;
   assign busy         = busy_q;
   assign underrun_cnt = underrun_q;

endmodule
